// File: rtl/fetch_controller_if.sv
// fetch_controller_if: bundles the instruction-memory request/response port
// and the fetched-instruction handshake toward decode.
// master = fetch controller side, slave = memory/decode side.
interface fetch_controller_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, issues one handshaked instruction-memory
// request at a time, buffers the returned word toward decode and applies
// branch / redirect updates to the PC.
// Optional macro FETCH_PERF_CNT_EN adds saturating performance counters
// (perf_fetched, perf_mem_wait, perf_flush).
module fetch_controller #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 branch,
    input  logic [ADDR_W-1:0]    branch_offset,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_mem_wait,
    output logic [31:0]          perf_flush,
`endif
    fetch_controller_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instrWord_q, instrWord_d;
    logic [ADDR_W-1:0] instrPc_q, instrPc_d;
    logic              instrValid_q, instrValid_d;

    logic              imemReq;
    logic              memAccept;
    logic              holdAccept;
    logic              flush;
    logic [ADDR_W-1:0] stepPc;
    logic [ADDR_W-1:0] nextPc;

    // Handshake qualifiers and the sequential PC after an accepted instruction.
    always_comb begin
        imemReq    = (state_q == FETCH) && !stall;
        memAccept  = imemReq && bus.imem_ready;
        holdAccept = (state_q == HOLD) && bus.instr_ready;
        flush      = redirect && (state_q != IDLE);
        stepPc     = pc_q + ADDR_W'(4) + (branch ? branch_offset : '0);
        nextPc     = stepPc & ~ADDR_W'(3);
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instrWord_d  = instrWord_q;
        instrPc_d    = instrPc_q;
        instrValid_d = instrValid_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (memAccept) begin
                    instrWord_d  = bus.imem_rdata;
                    instrPc_d    = pc_q;
                    instrValid_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (holdAccept) begin
                    instrValid_d = 1'b0;
                    pc_d         = nextPc;
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            pc_d         = redirect_pc & ~ADDR_W'(3);
            instrValid_d = 1'b0;
            instrWord_d  = instrWord_q;
            instrPc_d    = instrPc_q;
            state_d      = FETCH;
        end
    end

    // State, PC and instruction buffer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instrWord_q  <= '0;
            instrPc_q    <= '0;
            instrValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instrWord_q  <= instrWord_d;
            instrPc_q    <= instrPc_d;
            instrValid_q <= instrValid_d;
        end
    end

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instrValid_q;
    assign bus.instr       = instrWord_q;
    assign bus.instr_pc    = instrPc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfMemWait_q;
    logic [31:0] perfFlush_q;

    // Saturating event counters for fetch throughput analysis.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perfFetched_q <= '0;
            perfMemWait_q <= '0;
            perfFlush_q   <= '0;
        end else begin
            if (holdAccept && !flush && (perfFetched_q != '1)) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (imemReq && !bus.imem_ready && (perfMemWait_q != '1)) begin
                perfMemWait_q <= perfMemWait_q + 32'd1;
            end
            if (flush && (perfFlush_q != '1)) begin
                perfFlush_q <= perfFlush_q + 32'd1;
            end
        end
    end

    assign perf_fetched  = perfFetched_q;
    assign perf_mem_wait = perfMemWait_q;
    assign perf_flush    = perfFlush_q;
`endif

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the single-cycle MIPS datapath.
- Owns the PC and drives a handshaked instruction-memory port (req/ready, variable latency).
- Buffers the fetched word toward decode with a valid/ready handshake.
- Applies branch (PC+4+offset) and asynchronous redirect/flush requests, and honours a pipeline stall.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32: PC / address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  while 1, no new memory request is started.
- branch  in  1  the instruction being accepted by decode is a taken branch.
- branch_offset  in  32  sign-extended byte offset, added to PC+4 when branch=1.
- redirect  in  1  flush: abandon the current fetch and restart at redirect_pc.
- redirect_pc  in  32  restart address; bits [1:0] are ignored (forced 0).
- imem_req  out  1  memory request, held until imem_ready.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc hold a valid fetched instruction.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  address the instruction was fetched from.
- instr_ready  in  1  decode accepts the instruction this cycle.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- States: IDLE, FETCH, HOLD.
- IDLE: lasts exactly one cycle after reset release, then FETCH. This guarantees no request in the first post-reset cycle.
- FETCH:
  - imem_req = !stall; imem_addr = pc.
  - When imem_req && imem_ready: capture instr<=imem_rdata, instr_pc<=pc, instr_valid<=1; go to HOLD.
  - Minimum latency from req to instr_valid is 1 cycle (registered capture).
  - stall=1 drops imem_req and holds state. The memory is stateless, so a dropped request is legal.
- HOLD:
  - imem_req=0; instr_valid=1; instr and instr_pc stable.
  - On instr_ready=1: instr_valid<=0, pc<=next_pc, go to FETCH.
  - next_pc = pc+4+branch_offset if branch=1, else pc+4.
  - All arithmetic is modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 is legal).
  - next_pc[1:0] is forced to 0.
- branch and branch_offset are sampled only in the HOLD & instr_ready cycle; they are ignored otherwise.
- redirect (any state except IDLE) takes highest priority:
  - Next cycle: pc<=redirect_pc & ~3, instr_valid<=0, state=FETCH.
  - Any imem_ready data returning in the same cycle is discarded.
  - A concurrent instr_ready/branch is ignored; the instruction is squashed.
- redirect during IDLE is ignored.
- stall has no effect in HOLD: the buffered word remains deliverable.
- Reset asserted mid-fetch: outputs clear immediately, and the pending request is abandoned without waiting for imem_ready.
- At most one outstanding request; imem_ready while imem_req=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds three outputs, all cleared by reset_n and saturating at 32'hFFFF_FFFF:
  - perf_fetched[31:0]: increments on each HOLD→FETCH acceptance.
  - perf_mem_wait[31:0]: increments on each cycle with imem_req=1 && imem_ready=0.
  - perf_flush[31:0]: increments on each accepted redirect.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ready tied 1, instr_ready tied 1, RESET_PC=0 → imem_req first asserted on the 2nd cycle after release; instr_pc sequence 0,4,8,C; instr equals the memory contents.
- Memory latency 3 cycles at pc=0x10 → imem_req held for 3 cycles with imem_addr=0x10; instr_valid rises the cycle after imem_ready; no second request issued.
- In HOLD at pc=0x20, branch=1, branch_offset=0x40, instr_ready=1 → next imem_addr=0x64; with branch=0 → 0x24.
- Redirect to 0x103 while FETCH is waiting, with imem_ready in the same cycle → data discarded, instr_valid stays 0, next imem_addr=0x100.
- instr_ready=0 for 5 cycles in HOLD with stall toggling → instr and instr_pc stable, imem_req=0 throughout; acceptance then advances pc by 4.
- reset_n pulsed low mid-wait → imem_req and instr_valid drop within the same cycle; restart fetches from RESET_PC.
